// File: rtl/corr_pkt_pkg.sv
// Shared definitions for the correlator result packet.
//   PKT_NBYTES        number of bytes in one packet on the bytepipe
//   IDX_WIN..IDX_SYMDIFF  byte-index encoding used by the unpacker
//   corrPkt_t         parallel packet word, also used on the correlator side
//   next_idx()        byte-index successor with wrap at the last byte
package corr_pkt_pkg;

    localparam int PKT_NBYTES = 5;

    localparam logic [2:0] IDX_WIN     = 3'd0;
    localparam logic [2:0] IDX_X       = 3'd1;
    localparam logic [2:0] IDX_Y       = 3'd2;
    localparam logic [2:0] IDX_ISECT   = 3'd3;
    localparam logic [2:0] IDX_SYMDIFF = 3'd4;

    typedef struct packed {
        logic [7:0] winNum;
        logic [7:0] countX;
        logic [7:0] countY;
        logic [7:0] countIsect;
        logic [7:0] countSymdiff;
    } corrPkt_t;

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == 3'(PKT_NBYTES - 1)) ? IDX_WIN : idx + 3'd1;
    endfunction

endpackage

// File: rtl/corr_pkt_unpack_if.sv
// Bus bundle for corr_pkt_unpack.
//   bp_data/bp_valid/bp_ready    byte stream in (valid/ready)
//   pkt/pkt_valid/pkt_ready      reassembled packet out (valid/ready)
// Modports: master = stream source and packet sink, slave = the unpacker.
interface corr_pkt_unpack_if;
    import corr_pkt_pkg::*;

    logic [7:0] bp_data;
    logic       bp_valid;
    logic       bp_ready;
    corrPkt_t   pkt;
    logic       pkt_valid;
    logic       pkt_ready;

    modport master (
        output bp_data, bp_valid, pkt_ready,
        input  bp_ready, pkt, pkt_valid
    );

    modport slave (
        input  bp_data, bp_valid, pkt_ready,
        output bp_ready, pkt, pkt_valid
    );

endinterface

// File: rtl/corr_pkt_unpack_seq_check.sv
// corr_seq_check: winNum continuity checker for reassembled packets.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         a packet is being loaded this cycle (already clock-gated)
//   win_num      winNum of the packet being loaded
//   resync       forget the expected winNum (already clock-gated)
//   set_err      value seq_err takes on resync (1 for an idle-timeout resync)
//   n_dropped    saturating count of lost windows
//   seq_err      sticky discontinuity flag
module corr_seq_check #(
    parameter int DROPCOUNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [7:0]             win_num,
    input  logic                   resync,
    input  logic                   set_err,
    output logic [DROPCOUNT_W-1:0] n_dropped,
    output logic                   seq_err
);

    // Sum is wide enough for either operand plus a carry.
    localparam int SUM_W = ((DROPCOUNT_W > 8) ? DROPCOUNT_W : 8) + 1;

    function automatic logic [DROPCOUNT_W-1:0] sat_add(input logic [DROPCOUNT_W-1:0] cnt,
                                                       input logic [7:0] d);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(d);
        if (sum > SUM_W'({DROPCOUNT_W{1'b1}}))
            return {DROPCOUNT_W{1'b1}};
        return sum[DROPCOUNT_W-1:0];
    endfunction

    logic       exp_vld;
    logic [7:0] exp_win;
    logic [7:0] gap;

    // Modulo-256 distance; 255 followed by 0 gives zero.
    assign gap = win_num - exp_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_vld   <= 1'b0;
            exp_win   <= '0;
            n_dropped <= '0;
            seq_err   <= 1'b0;
        end else if (resync) begin
            exp_vld <= 1'b0;
            seq_err <= set_err;
        end else if (load) begin
            exp_win <= win_num + 8'd1;
            exp_vld <= 1'b1;
            if (exp_vld && gap != 8'd0) begin
                seq_err   <= 1'b1;
                n_dropped <= sat_add(n_dropped, gap);
            end
        end
    end

endmodule

// File: rtl/corr_pkt_unpack.sv
// corr_pkt_unpack: reassembles the correlator's 5-byte result packets
// (winNum, countX, countY, countIsect, countSymdiff) from a bytepipe into
// one parallel word and tracks winNum continuity.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_cg           clock-gate enable; all state holds when low
//   i_resync       abandon partial packet and forget the last winNum
//   bus            corr_pkt_unpack_if.slave (byte stream in, packet out)
//   o_nDropped     saturating lost-window count
//   o_seqErr       sticky winNum discontinuity flag
// Build option: define CORR_PKT_UNPACK_TIMEOUT_EN to add an idle timer that
// abandons a partial packet after 2**TIMEOUT_W-1 idle cycles.
module corr_pkt_unpack
    import corr_pkt_pkg::*;
#(
    parameter int DROPCOUNT_W = 16,
    parameter int TIMEOUT_W   = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cg,
    input  logic                   i_resync,
    corr_pkt_unpack_if.slave       bus,
    output logic [DROPCOUNT_W-1:0] o_nDropped,
    output logic                   o_seqErr
);

    logic [2:0] idx;
    logic [7:0] stg_win;
    logic [7:0] stg_x;
    logic [7:0] stg_y;
    logic [7:0] stg_isect;
    logic       stalled;
    logic       hs;
    logic       pop;
    logic       load;
    logic       resync_eff;
    logic       timeout_hit;

    // Only the final byte can be refused: it needs the output slot free.
    assign stalled      = (idx == IDX_SYMDIFF) && bus.pkt_valid && !bus.pkt_ready;
    assign bus.bp_ready = !stalled;

    assign hs         = i_cg && bus.bp_valid && bus.bp_ready;
    assign pop        = i_cg && bus.pkt_valid && bus.pkt_ready;
    assign resync_eff = i_cg && (i_resync || timeout_hit);
    // A resync in the same cycle drops the byte, so it cannot complete a packet.
    assign load       = hs && !resync_eff && (idx == IDX_SYMDIFF);

`ifdef CORR_PKT_UNPACK_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] idle_tmr;

    assign timeout_hit = &idle_tmr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idle_tmr <= '0;
        end else if (i_cg) begin
            if (hs || resync_eff)
                idle_tmr <= '0;
            else if (idx != IDX_WIN && !stalled)
                idle_tmr <= idle_tmr + TIMEOUT_W'(1);
        end
    end
`else
    // No idle timer in this build; the expression is constant false.
    assign timeout_hit = (TIMEOUT_W < 0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            idx <= IDX_WIN;
        else if (resync_eff)
            idx <= IDX_WIN;
        else if (hs)
            idx <= next_idx(idx);
    end

    // Staging holds bytes 0..3; contents are don't-care outside a packet.
    always_ff @(posedge i_clk) begin
        if (hs && !resync_eff) begin
            case (idx)
                IDX_WIN:   stg_win   <= bus.bp_data;
                IDX_X:     stg_x     <= bus.bp_data;
                IDX_Y:     stg_y     <= bus.bp_data;
                IDX_ISECT: stg_isect <= bus.bp_data;
                default:   ;
            endcase
        end
    end

    // A load on the same cycle as a pop keeps the slot full with the new packet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.pkt       <= '0;
            bus.pkt_valid <= 1'b0;
        end else if (load) begin
            bus.pkt       <= '{winNum: stg_win, countX: stg_x, countY: stg_y,
                               countIsect: stg_isect, countSymdiff: bus.bp_data};
            bus.pkt_valid <= 1'b1;
        end else if (pop) begin
            bus.pkt_valid <= 1'b0;
        end
    end

    corr_seq_check #(
        .DROPCOUNT_W (DROPCOUNT_W)
    ) u_seq_check (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (load),
        .win_num   (stg_win),
        .resync    (resync_eff),
        .set_err   (timeout_hit),
        .n_dropped (o_nDropped),
        .seq_err   (o_seqErr)
    );

endmodule

// File: tb/tb_corr_pkt_unpack.sv
// Testbench for corr_pkt_unpack: directed packet scenarios followed by a
// randomized phase; a monitor pops expected packets from a scoreboard queue
// whenever the DUT hands a packet downstream.
// Define CORR_PKT_UNPACK_TIMEOUT_EN to also exercise the idle timer.
`timescale 1ns/1ps
module tb_corr_pkt_unpack;
    import corr_pkt_pkg::*;

    localparam int DW  = 4;
    localparam int TW  = 4;
    localparam int MAXC = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cg = 1'b1;
    logic          resync = 1'b0;
    logic [DW-1:0] n_dropped;
    logic          seq_err;

    corr_pkt_unpack_if bus();

    corr_pkt_unpack #(.DROPCOUNT_W(DW), .TIMEOUT_W(TW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cg       (cg),
        .i_resync   (resync),
        .bus        (bus),
        .o_nDropped (n_dropped),
        .o_seqErr   (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        corrPkt_t pkt;
        int       nd;
        bit       se;
        int       epoch;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    // reference model of the continuity checker
    int         m_nd = 0;
    bit         m_se = 1'b0;
    bit         m_ev = 1'b0;
    logic [7:0] m_exp = 8'd0;
    int         epoch = 0;
    int         rdy_mode = 0;   // 0 always ready, 1 never ready, 2 random
    bit         rand_cg = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic pick_cg();
        if (rand_cg) return ($urandom_range(0, 7) != 0);
        return 1'b1;
    endfunction

    task automatic model_load(input corrPkt_t p);
        exp_t e;
        int   d;
        if (m_ev) begin
            d = (int'(p.winNum) - int'(m_exp) + 256) % 256;
            if (d != 0) begin
                m_se = 1'b1;
                m_nd = (m_nd + d > MAXC) ? MAXC : m_nd + d;
            end
        end
        m_exp = 8'((int'(p.winNum) + 1) % 256);
        m_ev  = 1'b1;
        e.pkt = p; e.nd = m_nd; e.se = m_se; e.epoch = epoch;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
        int n;
        bit hs;
        n  = 0;
        ok = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.bp_valid = 1'b0;
                cg = pick_cg();
            end
        end
        @(negedge clk);
        while (n < 300) begin
            bus.bp_valid = 1'b1;
            bus.bp_data  = b;
            cg = pick_cg();
            #1 hs = cg && bus.bp_ready;
            @(posedge clk);
            if (hs) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL byte_accept: byte %02h still pending after %0d cycles", b, n);
        end
    endtask

    task automatic post_load_check(input corrPkt_t p);
        @(negedge clk);
        bus.bp_valid = 1'b0;
        cg = 1'b1;
        #1;
        check("valid_after_load", 64'(bus.pkt_valid), 64'(1));
        check("win_after_load", 64'(bus.pkt.winNum), 64'(p.winNum));
    endtask

    task automatic send_pkt(input corrPkt_t p, input bit gaps);
        logic [7:0] b [5];
        bit ok;
        b[0] = p.winNum; b[1] = p.countX; b[2] = p.countY;
        b[3] = p.countIsect; b[4] = p.countSymdiff;
        for (int i = 0; i < 5; i++) begin
            send_byte(b[i], gaps, ok);
            if (!ok) return;
        end
        model_load(p);
        post_load_check(p);
    endtask

    function automatic corrPkt_t rnd_pkt(input logic [7:0] w);
        corrPkt_t p;
        p.winNum = w;
        p.countX = 8'($urandom); p.countY = 8'($urandom);
        p.countIsect = 8'($urandom); p.countSymdiff = 8'($urandom);
        return p;
    endfunction

    task automatic do_resync(input bit with_byte);
        @(negedge clk);
        resync = 1'b1;
        cg = 1'b1;
        bus.bp_valid = with_byte;
        bus.bp_data  = 8'($urandom);
        @(posedge clk);
        #1;
        resync = 1'b0;
        bus.bp_valid = 1'b0;
        m_ev = 1'b0;
        m_se = 1'b0;
        epoch++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rdy_mode = 0;
        cg = 1'b1;
        while ((sb.size() != 0 || bus.pkt_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL drain: %0d packets still expected, pkt_valid=%0b", sb.size(), bus.pkt_valid);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_bp_ready", 64'(bus.bp_ready), 64'(1));
        check("rst_pkt_valid", 64'(bus.pkt_valid), 64'(0));
        check("rst_pkt", 64'(bus.pkt), 64'(0));
        check("rst_nDropped", 64'(n_dropped), 64'(0));
        check("rst_seqErr", 64'(seq_err), 64'(0));
    endtask

    // Async reset with a partial packet in flight.
    task automatic do_reset();
        bit ok;
        drain();
        send_byte(8'($urandom), 1'b0, ok);
        send_byte(8'($urandom), 1'b0, ok);
        @(negedge clk);
        bus.bp_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        m_nd = 0; m_se = 1'b0; m_ev = 1'b0; epoch++;
    endtask

    // Monitor: drives downstream ready and checks every packet handed over.
    initial begin
        exp_t e;
        bus.pkt_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.pkt_ready = 1'b1;
                1:       bus.pkt_ready = 1'b0;
                default: bus.pkt_ready = ($urandom_range(0, 2) != 0);
            endcase
            #2;
            if (!rst && cg && bus.pkt_valid && bus.pkt_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pkt: got %010h with nothing expected", bus.pkt);
                end else begin
                    e = sb.pop_front();
                    check("pkt", 64'(bus.pkt), 64'(e.pkt));
                    check("nDropped", 64'(n_dropped), 64'(e.nd));
                    if (e.epoch == epoch)
                        check("seqErr", 64'(seq_err), 64'(e.se));
                end
            end
        end
    end

    initial begin
        corrPkt_t   pa, pb;
        logic [7:0] w;
        logic [7:0] b [5];
        bit         ok;
        int         r;
        int         nb;

        bus.bp_valid = 1'b0;
        bus.bp_data  = 8'd0;

        #12 check_reset_vals();
        @(negedge clk);
        rst = 1'b0;

        // basic packet
        pa = '{winNum: 8'h00, countX: 8'h11, countY: 8'h22, countIsect: 8'h33, countSymdiff: 8'h44};
        send_pkt(pa, 1'b0);
        drain();
        check("t1_nDropped", 64'(n_dropped), 64'(0));
        check("t1_seqErr", 64'(seq_err), 64'(0));

        // winNum wrap is continuous
        do_resync(1'b0);
        send_pkt(rnd_pkt(8'hFE), 1'b0);
        send_pkt(rnd_pkt(8'hFF), 1'b0);
        send_pkt(rnd_pkt(8'h00), 1'b0);
        send_pkt(rnd_pkt(8'h01), 1'b0);
        drain();
        check("t2_nDropped", 64'(n_dropped), 64'(0));
        check("t2_seqErr", 64'(seq_err), 64'(0));

        // gap, then resync clears the flag but not the count
        do_reset();
        send_pkt(rnd_pkt(8'h05), 1'b0);
        send_pkt(rnd_pkt(8'h09), 1'b0);
        drain();
        check("t3_nDropped", 64'(n_dropped), 64'(m_nd));
        check("t3_seqErr", 64'(seq_err), 64'(1));
        do_resync(1'b1);
        check("t3_seqErr_resync", 64'(seq_err), 64'(0));
        send_pkt(rnd_pkt(8'h20), 1'b0);
        drain();
        check("t3_nDropped_after", 64'(n_dropped), 64'(m_nd));
        check("t3_seqErr_after", 64'(seq_err), 64'(0));

        // backpressure: second packet's last byte waits, then pop+load together
        rdy_mode = 1;
        pa = rnd_pkt(m_exp);
        send_pkt(pa, 1'b0);
        pb = rnd_pkt(m_exp);
        b[0] = pb.winNum; b[1] = pb.countX; b[2] = pb.countY;
        b[3] = pb.countIsect; b[4] = pb.countSymdiff;
        for (int i = 0; i < 4; i++) send_byte(b[i], 1'b0, ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.bp_valid = 1'b1;
            bus.bp_data  = b[4];
            cg = 1'b1;
            #1;
            check("t4_bp_ready_stall", 64'(bus.bp_ready), 64'(0));
            check("t4_hold_valid", 64'(bus.pkt_valid), 64'(1));
            check("t4_hold_win", 64'(bus.pkt.winNum), 64'(pa.winNum));
        end
        rdy_mode = 0;
        send_byte(b[4], 1'b0, ok);
        if (ok) begin
            model_load(pb);
            post_load_check(pb);
        end
        drain();

        // saturation of the lost-window counter
        do_reset();
        w = 8'h00;
        for (int i = 0; i < 4; i++) begin
            send_pkt(rnd_pkt(w), 1'b0);
            w = w + 8'd11;
        end
        drain();
        check("t5_nDropped_sat", 64'(n_dropped), 64'(MAXC));
        check("t5_model_sat", 64'(m_nd), 64'(MAXC));

`ifdef CORR_PKT_UNPACK_TIMEOUT_EN
        // idle timeout abandons a partial packet and flags an error
        send_byte(8'h40, 1'b0, ok);
        send_byte(8'h41, 1'b0, ok);
        @(negedge clk);
        bus.bp_valid = 1'b0;
        repeat (20) @(negedge clk);
        m_ev = 1'b0; m_se = 1'b1; epoch++;
        #1 check("t6_seqErr_timeout", 64'(seq_err), 64'(1));
        send_pkt(rnd_pkt(8'h77), 1'b0);
        drain();
        check("t6_seqErr_after", 64'(seq_err), 64'(1));
`endif

        // randomized traffic
        rand_cg  = 1'b1;
        rdy_mode = 2;
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 19);
            if (r < 2) begin
                nb = $urandom_range(1, 4);
                for (int i = 0; i < nb; i++) send_byte(8'($urandom), 1'b1, ok);
                do_resync($urandom_range(0, 1) == 1);
            end else if (r == 2) begin
                do_resync($urandom_range(0, 1) == 1);
            end else begin
                case ($urandom_range(0, 5))
                    0:       w = 8'($urandom);
                    1:       w = m_exp + 8'($urandom_range(1, 5));
                    default: w = m_exp;
                endcase
                send_pkt(rnd_pkt(w), 1'b1);
            end
            if (k == 40) begin
                rand_cg = 1'b0;
                do_reset();
                rand_cg  = 1'b1;
                rdy_mode = 2;
            end
        end

        rand_cg = 1'b0;
        drain();
        check("sb_empty", 64'(sb.size()), 64'(0));
        check("final_nDropped", 64'(n_dropped), 64'(m_nd));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
